cordic_seq_ctrl: RTL and testbench

Parametrised sequencing controller for the iterative CORDIC sine/cosine/arctangent datapath. It steps the shared add/subtract unit through the X, Y and Z updates of every iteration, with a runtime-selectable iteration count and rotation or vectoring mode. It also selects the quadrant-corrected result and guards the add/subtract handshake with a timeout. It sits between the host start/ack interface and the CORDIC datapath registers, counters and muxes.

---
 rtl/cordic_seq_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_cordic_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_seq_ctrl.sv
// Sequencing controller for the iterative CORDIC datapath.
// Steps one shared add/subtract unit through the X, Y and Z updates of each
// iteration, selects the quadrant-corrected result, and guards every add/sub
// handshake with a timeout that ends the operation in an error state.
module cordic_seq_ctrl #(
  parameter int ITER_W   = 5,
  parameter int MAX_ITER = 24,
  parameter int TO_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ack,
  input  logic              op,
  input  logic              mode,
  input  logic [1:0]        region,
  input  logic [ITER_W-1:0] n_iter,
  input  logic              au_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              au_start,
  output logic              au_ack,
  output logic [ITER_W-1:0] iter_idx,
  output logic [1:0]        var_sel,
  output logic              first_sel,
  output logic              sign_src,
  output logic              en_in,
  output logic              en_stage,
  output logic              en_shift,
  output logic              en_x,
  output logic              en_y,
  output logic              en_z,
  output logic              en_res,
  output logic              en_out,
  output logic [1:0]        out_sel,
  output logic              out_neg
);

  typedef enum logic [3:0] {
    IDLE, LOAD, PREP, SHIFT, ISSUE, WAIT, NEXT, FINAL, OUT, DONE, ERR
  } state_t;

  // The iteration count is stored as N-1 so that N = 2**ITER_W still fits.
  localparam logic [ITER_W:0]   MAX_N    = (ITER_W+1)'(MAX_ITER);
  localparam logic [ITER_W-1:0] MAX_LAST = ITER_W'(MAX_ITER - 1);
  // One step below all-ones: the increment that would reach all-ones ends in ERR.
  localparam logic [TO_W-1:0]   TO_LAST  = {{(TO_W-1){1'b1}}, 1'b0};

  state_t            state_q, state_d;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] n_last_q;
  logic [ITER_W-1:0] n_last_d;
  logic [1:0]        var_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              op_q;
  logic              mode_q;
  logic [1:0]        region_q;
  logic [1:0]        out_sel_q, out_sel_d;
  logic              out_neg_q, out_neg_d;

  // Control strobes from the FSM to the counter/latch registers.
  logic take_start;
  logic cnt_clr;
  logic cnt_inc;
  logic var_inc;
  logic var_clr;
  logic iter_inc;
  logic load_out;
  logic clr_out;

  // Clamp the requested iteration count to 1..MAX_ITER, expressed as N-1.
  always_comb begin
    if (n_iter == '0) begin
      n_last_d = '0;
    end else if ({1'b0, n_iter} > MAX_N) begin
      n_last_d = MAX_LAST;
    end else begin
      n_last_d = n_iter - ITER_W'(1);
    end
  end

  // Quadrant-corrected result selection from the latched op, mode and region.
  always_comb begin
    out_sel_d = 2'b10;
    out_neg_d = 1'b0;
    if (!mode_q) begin
      if (!op_q) begin
        out_sel_d = (region_q == 2'b00 || region_q == 2'b11) ? 2'b00 : 2'b01;
        out_neg_d = region_q[1] ^ region_q[0];
      end else begin
        out_sel_d = (region_q == 2'b00 || region_q == 2'b11) ? 2'b01 : 2'b00;
        out_neg_d = region_q[1];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers update
    // from the same pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and per-state output strobes.
  always_comb begin
    // NOTE: every output of this block is given a default first; a path that
    // left one unassigned would infer a latch.
    state_d    = state_q;
    take_start = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    var_inc    = 1'b0;
    var_clr    = 1'b0;
    iter_inc   = 1'b0;
    load_out   = 1'b0;
    clr_out    = 1'b0;
    au_start   = 1'b0;
    au_ack     = 1'b0;
    first_sel  = 1'b0;
    en_in      = 1'b0;
    en_stage   = 1'b0;
    en_shift   = 1'b0;
    en_x       = 1'b0;
    en_y       = 1'b0;
    en_z       = 1'b0;
    en_res     = 1'b0;
    en_out     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          take_start = 1'b1;
          en_in      = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        en_in   = 1'b1;
        state_d = PREP;
      end
      PREP: begin
        en_stage  = 1'b1;
        first_sel = (iter_q != '0);
        state_d   = SHIFT;
      end
      SHIFT: begin
        en_shift = 1'b1;
        state_d  = ISSUE;
      end
      ISSUE: begin
        au_start = 1'b1;
        cnt_clr  = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        // A result arriving on the terminal-count cycle still wins.
        if (au_ready) begin
          au_ack = 1'b1;
          en_x   = (var_q == 2'd0);
          en_y   = (var_q == 2'd1);
          en_z   = (var_q == 2'd2);
          state_d = NEXT;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ERR;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      NEXT: begin
        if (var_q != 2'd2) begin
          var_inc = 1'b1;
          state_d = ISSUE;
        end else begin
          var_clr = 1'b1;
          if (iter_q == n_last_q) begin
            load_out = 1'b1;
            state_d  = FINAL;
          end else begin
            iter_inc = 1'b1;
            state_d  = PREP;
          end
        end
      end
      FINAL: begin
        en_res  = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        en_out  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (ack) begin
          clr_out = 1'b1;
          state_d = IDLE;
        end
      end
      ERR: begin
        busy  = 1'b0;
        done  = 1'b1;
        error = 1'b1;
        if (ack) begin
          clr_out = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Operation latches, iteration/variable indices, timeout counter and result select.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= 1'b0;
      mode_q    <= 1'b0;
      region_q  <= 2'b00;
      n_last_q  <= '0;
      iter_q    <= '0;
      var_q     <= 2'd0;
      to_cnt_q  <= '0;
      out_sel_q <= 2'b00;
      out_neg_q <= 1'b0;
    end else begin
      if (take_start) begin
        op_q     <= op;
        mode_q   <= mode;
        region_q <= region;
        n_last_q <= n_last_d;
        iter_q   <= '0;
        var_q    <= 2'd0;
      end else begin
        if (var_inc) begin
          var_q <= var_q + 2'd1;
        end else if (var_clr) begin
          var_q <= 2'd0;
        end
        if (iter_inc) begin
          iter_q <= iter_q + ITER_W'(1);
        end
      end
      if (cnt_clr) begin
        to_cnt_q <= '0;
      end else if (cnt_inc) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      if (load_out) begin
        out_sel_q <= out_sel_d;
        out_neg_q <= out_neg_d;
      end else if (clr_out) begin
        out_sel_q <= 2'b00;
        out_neg_q <= 1'b0;
      end
    end
  end

  assign iter_idx = iter_q;
  assign var_sel  = var_q;
  assign sign_src = mode_q;
  assign out_sel  = out_sel_q;
  assign out_neg  = out_neg_q;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Self-checking bench for cordic_seq_ctrl: directed cases for the corner
// behaviour plus randomized operations, each compared against counts,
// latencies and result selects derived from the controller's rules.
module tb_cordic_seq_ctrl;

  localparam int ITER_W   = 5;
  localparam int MAX_ITER = 24;
  localparam int TO_W     = 8;

  // Event counters kept by the monitor.
  localparam int C_AU_START = 0;
  localparam int C_AU_ACK   = 1;
  localparam int C_EN_X     = 2;
  localparam int C_EN_Y     = 3;
  localparam int C_EN_Z     = 4;
  localparam int C_EN_IN    = 5;
  localparam int C_EN_SHIFT = 6;
  localparam int C_EN_RES   = 7;
  localparam int C_EN_OUT   = 8;
  localparam int C_BAD_VAR  = 9;
  localparam int C_BAD_SIGN = 10;
  localparam int C_EN_STAGE = 11;
  localparam int NCNT       = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              ack;
  logic              op;
  logic              mode;
  logic [1:0]        region;
  logic [ITER_W-1:0] n_iter;
  logic              au_ready;
  logic              busy, done, error, au_start, au_ack;
  logic [ITER_W-1:0] iter_idx;
  logic [1:0]        var_sel;
  logic              first_sel, sign_src;
  logic              en_in, en_stage, en_shift, en_x, en_y, en_z, en_res, en_out;
  logic [1:0]        out_sel;
  logic              out_neg;

  int vectors     = 0;
  int miscompares = 0;

  int lat      = 1;
  bit resp_en  = 1'b1;
  bit cur_mode = 1'b0;

  int cnt [NCNT];
  int stage_iter[$];
  int stage_first[$];

  cordic_seq_ctrl #(.ITER_W(ITER_W), .MAX_ITER(MAX_ITER), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack), .op(op), .mode(mode),
    .region(region), .n_iter(n_iter), .au_ready(au_ready), .busy(busy),
    .done(done), .error(error), .au_start(au_start), .au_ack(au_ack),
    .iter_idx(iter_idx), .var_sel(var_sel), .first_sel(first_sel),
    .sign_src(sign_src), .en_in(en_in), .en_stage(en_stage), .en_shift(en_shift),
    .en_x(en_x), .en_y(en_y), .en_z(en_z), .en_res(en_res), .en_out(en_out),
    .out_sel(out_sel), .out_neg(out_neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  // Add/sub unit model: answers L cycles after each au_start.
  initial begin
    au_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (au_start && resp_en) begin
        for (int i = 0; i < lat; i++) @(posedge clk);
        #1 au_ready = 1'b1;
        @(posedge clk);
        #1 au_ready = 1'b0;
      end
    end
  end

  // Monitor: tallies strobes and records iteration index at each stage load.
  initial begin
    for (int i = 0; i < NCNT; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (au_start) cnt[C_AU_START]++;
      if (au_ack)   cnt[C_AU_ACK]++;
      if (en_x)     cnt[C_EN_X]++;
      if (en_y)     cnt[C_EN_Y]++;
      if (en_z)     cnt[C_EN_Z]++;
      if (en_in)    cnt[C_EN_IN]++;
      if (en_shift) cnt[C_EN_SHIFT]++;
      if (en_res)   cnt[C_EN_RES]++;
      if (en_out)   cnt[C_EN_OUT]++;
      if ((en_x && var_sel != 2'd0) || (en_y && var_sel != 2'd1) || (en_z && var_sel != 2'd2))
        cnt[C_BAD_VAR]++;
      if (busy && sign_src !== cur_mode) cnt[C_BAD_SIGN]++;
      if (en_stage) begin
        cnt[C_EN_STAGE]++;
        stage_iter.push_back(int'(iter_idx));
        stage_first.push_back(int'(first_sel));
      end
    end
  end

  function automatic int eff_n(input int n);
    if (n == 0) return 1;
    if (n > MAX_ITER) return MAX_ITER;
    return n;
  endfunction

  // One full operation, checked against the controller's rules.
  task automatic run_op(input int n, input bit o, input bit m, input logic [1:0] r,
                        input int l, input bit poke, input bit ack_start);
    int neff, exp_cyc, cyc, qbase, bad_seq;
    int base [NCNT];
    logic [1:0] exp_sel;
    logic exp_neg;
    neff    = eff_n(n);
    exp_cyc = neff * (3 * l + 8) + 4;
    if (m) begin
      exp_sel = 2'b10; exp_neg = 1'b0;
    end else if (!o) begin
      exp_sel = (r == 2'b00 || r == 2'b11) ? 2'b00 : 2'b01;
      exp_neg = (r == 2'b01 || r == 2'b10);
    end else begin
      exp_sel = (r == 2'b00 || r == 2'b11) ? 2'b01 : 2'b00;
      exp_neg = (r >= 2'b10);
    end
    lat = l; resp_en = 1'b1; cur_mode = m;
    base = cnt; qbase = stage_iter.size();
    @(posedge clk); #1;
    start = 1'b1; n_iter = ITER_W'(n); op = o; mode = m; region = r;
    @(posedge clk); #1;
    start = 1'b0;
    op = 1'($urandom); mode = 1'($urandom); region = 2'($urandom); n_iter = ITER_W'($urandom);
    cyc = 1;
    while (!done && cyc < exp_cyc + 50) begin
      @(posedge clk); #1;
      cyc++;
      start = poke && (cyc == 6);
    end
    start = 1'b0;
    check("done_latency", cyc, exp_cyc);
    check("done", done, 1);
    check("error_clear", error, 0);
    check("busy_in_done", busy, 0);
    check("out_sel", out_sel, exp_sel);
    check("out_neg", out_neg, exp_neg);
    check("au_start_cnt", cnt[C_AU_START] - base[C_AU_START], 3 * neff);
    check("au_ack_cnt", cnt[C_AU_ACK] - base[C_AU_ACK], 3 * neff);
    check("en_x_cnt", cnt[C_EN_X] - base[C_EN_X], neff);
    check("en_y_cnt", cnt[C_EN_Y] - base[C_EN_Y], neff);
    check("en_z_cnt", cnt[C_EN_Z] - base[C_EN_Z], neff);
    check("en_in_cnt", cnt[C_EN_IN] - base[C_EN_IN], 2);
    check("en_shift_cnt", cnt[C_EN_SHIFT] - base[C_EN_SHIFT], neff);
    check("en_res_cnt", cnt[C_EN_RES] - base[C_EN_RES], 1);
    check("en_out_cnt", cnt[C_EN_OUT] - base[C_EN_OUT], 1);
    check("var_sel_at_store", cnt[C_BAD_VAR] - base[C_BAD_VAR], 0);
    check("sign_src_hold", cnt[C_BAD_SIGN] - base[C_BAD_SIGN], 0);
    check("stage_cnt", stage_iter.size() - qbase, neff);
    bad_seq = 0;
    for (int i = 0; i < neff && qbase + i < stage_iter.size(); i++) begin
      if (stage_iter[qbase + i] != i) bad_seq++;
      if (stage_first[qbase + i] != ((i != 0) ? 1 : 0)) bad_seq++;
    end
    check("iter_first_seq", bad_seq, 0);
    repeat (2) @(posedge clk);
    #1 check("done_held", done, 1);
    ack = 1'b1; start = ack_start;
    @(posedge clk); #1;
    ack = 1'b0; start = 1'b0;
    check("idle_after_ack", busy, 0);
    check("done_after_ack", done, 0);
    check("out_sel_cleared", {out_neg, out_sel}, 0);
    @(posedge clk); #1;
    check("start_with_ack_ignored", busy, 0);
  endtask

  // Operation whose add/sub never answers in time.
  task automatic run_timeout(input int l, input bit use_resp);
    int cyc;
    int base [NCNT];
    lat = l; resp_en = use_resp; cur_mode = 1'b0;
    base = cnt;
    @(posedge clk); #1;
    start = 1'b1; n_iter = ITER_W'(1); op = 1'b0; mode = 1'b0; region = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("err_latency", cyc, 4 + (2 ** TO_W - 1) + 1);
    check("err_error", error, 1);
    check("err_done", done, 1);
    check("err_busy", busy, 0);
    check("err_au_start_cnt", cnt[C_AU_START] - base[C_AU_START], 1);
    check("err_no_store", cnt[C_EN_X] - base[C_EN_X], 0);
    repeat (3) @(posedge clk);
    #1 check("err_held", error, 1);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check("err_cleared", error, 0);
    check("err_done_cleared", done, 0);
    repeat (3) @(posedge clk);
    resp_en = 1'b1;
  endtask

  // Reset during WAIT of iteration 2, then quiet, then a clean run.
  task automatic run_reset_mid();
    bit found;
    int base [NCNT];
    lat = 2; resp_en = 1'b1; cur_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; n_iter = ITER_W'(4); op = 1'b0; mode = 1'b1; region = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (au_start && iter_idx == ITER_W'(2)) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("reached_iter2", found, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_iter_idx", iter_idx, 0);
    check("rst_var_sel", var_sel, 0);
    check("rst_sign_src", sign_src, 0);
    base = cnt;
    repeat (8) @(posedge clk);
    #1;
    check("rst_no_au_start", cnt[C_AU_START] - base[C_AU_START], 0);
    check("rst_no_enables",
          (cnt[C_EN_X] - base[C_EN_X]) + (cnt[C_EN_Y] - base[C_EN_Y]) +
          (cnt[C_EN_Z] - base[C_EN_Z]) + (cnt[C_EN_STAGE] - base[C_EN_STAGE]) +
          (cnt[C_EN_SHIFT] - base[C_EN_SHIFT]) + (cnt[C_EN_IN] - base[C_EN_IN]), 0);
    run_op(3, 1'b1, 1'b0, 2'b11, 1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ack = 1'b0; op = 1'b0; mode = 1'b0;
    region = 2'b00; n_iter = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done_error", {done, error}, 0);
    check("reset_strobes", {au_start, au_ack, en_in, en_stage, en_shift, en_x, en_y, en_z,
                            en_res, en_out, first_sel}, 0);
    check("reset_iter_var", {iter_idx, var_sel}, 0);
    check("reset_out", {sign_src, out_sel, out_neg}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(1, 1'b0, 1'b0, 2'b00, 1, 1'b0, 1'b0);
    run_op(3, 1'b1, 1'b0, 2'b10, 2, 1'b0, 1'b0);
    run_op(0, 1'b0, 1'b0, 2'b01, 1, 1'b0, 1'b0);
    run_op(31, 1'b1, 1'b0, 2'b11, 1, 1'b0, 1'b0);
    run_op(2, 1'b1, 1'b1, 2'b10, 3, 1'b0, 1'b0);
    run_op(2, 1'b0, 1'b0, 2'b10, 1, 1'b1, 1'b1);
    run_op(1, 1'b0, 1'b0, 2'b00, 2 ** TO_W - 1, 1'b0, 1'b0);
    run_timeout(1, 1'b0);
    run_timeout(2 ** TO_W, 1'b1);
    run_reset_mid();

    for (int k = 0; k < 14; k++) begin
      run_op($urandom_range(0, 31), 1'($urandom), 1'($urandom), 2'($urandom),
             $urandom_range(1, 4), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
